avalon_burst_ram_slave: RTL and testbench



---
 rtl/avalon_burst_ram_slave_pkg.sv | 16 +
 rtl/avalon_burst_ram_slave_if.sv | 24 ++
 rtl/avalon_burst_ram_slave_be_sync_ram.sv | 21 ++
 rtl/avalon_burst_ram_slave.sv | 97 +++++++++
 tb/tb_avalon_burst_ram_slave.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_burst_ram_slave_pkg.sv
// avalon_burst_ram_slave_pkg: shared widths, FSM state type and burst-length helper
// No ports; imported by the interface, the RAM and the slave top.
package avalon_burst_ram_slave_pkg;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_ADDR_W = 30;
    localparam int BURST_W    = 5;
    localparam int LINE_BEATS = 16;
    localparam int BE_W       = BUS_DATA_W / 8;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    // A burstcount of 0 means one beat; anything above max_b is clamped.
    function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] bc, input logic [BURST_W-1:0] max_b);
        return (bc == '0) ? BURST_W'(1) : (bc > max_b) ? max_b : bc;
    endfunction
endpackage

// File: rtl/avalon_burst_ram_slave_if.sv
// avalon_burst_ram_slave_if: Avalon-MM burst bus between a CPU master and the RAM slave
// Signals: s_waitrequest, s_readdata, s_readdatavalid (slave to master);
//          s_burstcount, s_writedata, s_address, s_write, s_read, s_byteenable (master to slave).
interface avalon_burst_ram_slave_if;
    import avalon_burst_ram_slave_pkg::*;
    logic                  s_waitrequest;
    logic [BUS_DATA_W-1:0] s_readdata;
    logic                  s_readdatavalid;
    logic [BURST_W-1:0]    s_burstcount;
    logic [BUS_DATA_W-1:0] s_writedata;
    logic [BUS_ADDR_W-1:0] s_address;
    logic                  s_write;
    logic                  s_read;
    logic [BE_W-1:0]       s_byteenable;

    modport master (
        input  s_waitrequest, s_readdata, s_readdatavalid,
        output s_burstcount, s_writedata, s_address, s_write, s_read, s_byteenable
    );
    modport slave (
        output s_waitrequest, s_readdata, s_readdatavalid,
        input  s_burstcount, s_writedata, s_address, s_write, s_read, s_byteenable
    );
endinterface

// File: rtl/avalon_burst_ram_slave_be_sync_ram.sv
// avalon_burst_ram_slave_be_sync_ram: single-port RAM, 1-cycle read latency, byte-lane writes
module avalon_burst_ram_slave_be_sync_ram
  import avalon_burst_ram_slave_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter     INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [BE_W-1:0]       we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [BUS_DATA_W-1:0] wdata,
  output logic [BUS_DATA_W-1:0] rdata
);
  logic [BE_W-1:0][7:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++)
      if (we[i]) mem[addr][i] <= wdata[i*8 +: 8];
    if (en) rdata <= mem[addr];
  end
endmodule

// File: rtl/avalon_burst_ram_slave.sv
// avalon_burst_ram_slave: Avalon-MM burst slave (single words and 16-beat lines) over on-chip RAM
// Ports: clk; rst (sync, active-high); bus (slave modport of avalon_burst_ram_slave_if).
module avalon_burst_ram_slave
    import avalon_burst_ram_slave_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MAX_BURST = LINE_BEATS,
    parameter     INIT_FILE = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    avalon_burst_ram_slave_if.slave bus
);
    state_t                state, state_nx;
    logic [ADDR_W-1:0]     addr, addr_nx, ram_addr;
    logic [BURST_W-1:0]    cnt, cnt_nx, n;
    logic [BE_W-1:0]       ram_we;
    logic                  ram_en, ram_rd_v;
    logic [BUS_DATA_W-1:0] ram_q;
    logic                  unused_addr_hi;

    assign unused_addr_hi    = ^bus.s_address[BUS_ADDR_W-1:ADDR_W];
    assign n                 = burst_len(bus.s_burstcount, BURST_W'(MAX_BURST));
    assign bus.s_waitrequest = rst || state == RD_BURST;

    // cnt holds beats still to write/issue after the one taken in IDLE.
    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        cnt_nx   = cnt;
        ram_addr = addr;
        ram_we   = '0;
        ram_en   = 1'b0;
        case (state)
            IDLE: if (bus.s_write || bus.s_read) begin
                ram_addr = bus.s_address[ADDR_W-1:0];
                addr_nx  = ram_addr + 1'b1;
                cnt_nx   = n - 1'b1;
                if (bus.s_write) begin
                    ram_we   = bus.s_byteenable;
                    state_nx = (n > BURST_W'(1)) ? WR_BURST : IDLE;
                end else begin
                    ram_en   = 1'b1;
                    state_nx = RD_BURST;
                end
            end
            WR_BURST: if (bus.s_write) begin
                ram_we  = bus.s_byteenable;
                addr_nx = addr + 1'b1;
                cnt_nx  = cnt - 1'b1;
                if (cnt == BURST_W'(1)) state_nx = IDLE;
            end
            RD_BURST: begin
                if (cnt != '0) begin
                    ram_en  = 1'b1;
                    addr_nx = addr + 1'b1;
                    cnt_nx  = cnt - 1'b1;
                end else if (!ram_rd_v) begin
                    // last RAM word already moved into s_readdata this cycle
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            ram_we = '0;
            ram_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            addr                <= '0;
            cnt                 <= '0;
            ram_rd_v            <= 1'b0;
            bus.s_readdatavalid <= 1'b0;
            bus.s_readdata      <= '0;
        end else begin
            state               <= state_nx;
            addr                <= addr_nx;
            cnt                 <= cnt_nx;
            ram_rd_v            <= ram_en;
            bus.s_readdatavalid <= ram_rd_v;
            if (ram_rd_v) bus.s_readdata <= ram_q;
        end
    end

    avalon_burst_ram_slave_be_sync_ram #(.ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)) be_sync_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.s_writedata),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_avalon_burst_ram_slave.sv
// tb_avalon_burst_ram_slave: directed stimulus with a read-beat scoreboard for avalon_burst_ram_slave
module tb_avalon_burst_ram_slave;
    import avalon_burst_ram_slave_pkg::*;
    localparam int AW = 12;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] pend[$];
    logic [31:0] wdat[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_burst_ram_slave_if bus();
    avalon_burst_ram_slave #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.s_readdatavalid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got beat %h required no beat (cycle %0d)", bus.s_readdata, cyc);
            end else begin
                e = sb.pop_front();
                check("rd_data", bus.s_readdata, e.d);
                check("rd_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 50 && bus.s_waitrequest; k++) step();
        check("wait_ready", 32'(bus.s_waitrequest), 32'd0);
    endtask

    task automatic wr_burst(input logic [29:0] a, input logic [4:0] bc, input int beats,
                            input logic [3:0] be, input int gap_at, input int gap_len);
        wait_ready();
        for (int i = 0; i < beats; i++) begin
            if (i == gap_at) begin
                bus.s_write = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    check("gap_state", 32'(dut.state), 32'(WR_BURST));
                    check("gap_wait", 32'(bus.s_waitrequest), 32'd0);
                    step();
                end
            end
            bus.s_write        = 1'b1;
            bus.s_address      = a;
            bus.s_burstcount   = bc;
            bus.s_writedata    = wdat[i];
            bus.s_byteenable   = be;
            step();
        end
        bus.s_write = 1'b0;
    endtask

    // Expected beats are queued in pend beforehand; they are due in cycles T+2.. after acceptance at T.
    task automatic issue_read(input logic [29:0] a, input logic [4:0] bc);
        wait_ready();
        for (int i = 0; i < pend.size(); i++) sb.push_back('{d: pend[i], c: cyc + 2 + i});
        pend.delete();
        bus.s_read       = 1'b1;
        bus.s_address    = a;
        bus.s_burstcount = bc;
        step();
        bus.s_read = 1'b0;
    endtask

    task automatic wait_window(input int n);
        for (int k = 1; k <= n + 1; k++) begin
            check($sformatf("wait_hi_%0d", k), 32'(bus.s_waitrequest), 32'd1);
            step();
        end
        check("wait_lo", 32'(bus.s_waitrequest), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.s_write      = 1'b0;
        bus.s_read       = 1'b0;
        bus.s_address    = '0;
        bus.s_burstcount = '0;
        bus.s_writedata  = '0;
        bus.s_byteenable = '0;
        repeat (3) step();
        check("rst_wait", 32'(bus.s_waitrequest), 32'd1);
        check("rst_rdv", 32'(bus.s_readdatavalid), 32'd0);
        check("rst_rdata", bus.s_readdata, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_wait", 32'(bus.s_waitrequest), 32'd0);

        // single beat write then read (read-after-write in the next cycle)
        wdat[0] = 32'hDEADBEEF;
        wr_burst(30'h10, 5'd1, 1, 4'hF, -1, 0);
        pend.push_back(32'hDEADBEEF);
        issue_read(30'h10, 5'd1);
        wait_window(1);

        // full line write and read
        for (int i = 0; i < 16; i++) wdat[i] = 32'(i);
        wr_burst(30'h40, 5'd16, 16, 4'hF, -1, 0);
        for (int i = 0; i < 16; i++) pend.push_back(32'(i));
        issue_read(30'h40, 5'd16);
        wait_window(16);

        // write burst with a 3-cycle bubble before beat 2
        for (int i = 0; i < 4; i++) wdat[i] = 32'hB0 + 32'(i);
        wr_burst(30'h80, 5'd4, 4, 4'hF, 2, 3);
        for (int i = 0; i < 4; i++) pend.push_back(32'hB0 + 32'(i));
        issue_read(30'h80, 5'd4);
        wait_window(4);

        // byte enables: lanes 0 and 2 only
        wdat[0] = 32'h11223344;
        wr_burst(30'h5, 5'd1, 1, 4'hF, -1, 0);
        wdat[0] = 32'hAABBCCDD;
        wr_burst(30'h5, 5'd1, 1, 4'h5, -1, 0);
        pend.push_back(32'h11BB33DD);
        issue_read(30'h5, 5'd1);
        wait_window(1);

        // address wrap inside a burst and aliasing of upper bits
        for (int i = 0; i < 4; i++) wdat[i] = 32'hC0 + 32'(i);
        wr_burst(30'd4094, 5'd4, 4, 4'hF, -1, 0);
        for (int i = 0; i < 4; i++) pend.push_back(32'hC0 + 32'(i));
        issue_read(30'd4094, 5'd4);
        wait_window(4);
        pend.push_back(32'hC2);
        pend.push_back(32'hC3);
        issue_read(30'h1000, 5'd2);
        wait_window(2);

        // burstcount 0 is a single beat
        wdat[0] = 32'h55;
        wr_burst(30'h200, 5'd0, 1, 4'hF, -1, 0);
        check("bc0_idle", 32'(dut.state), 32'(IDLE));
        wdat[0] = 32'h66;
        wr_burst(30'h202, 5'd1, 1, 4'hF, -1, 0);
        pend.push_back(32'h55);
        issue_read(30'h200, 5'd0);
        wait_window(1);
        pend.push_back(32'h66);
        issue_read(30'h202, 5'd1);
        wait_window(1);

        // burstcount above MAX_BURST is clamped to 16 beats
        for (int i = 0; i < 16; i++) pend.push_back(32'(i));
        issue_read(30'h40, 5'd20);
        wait_window(16);

        // write and read together: write wins, read dropped
        wait_ready();
        bus.s_write      = 1'b1;
        bus.s_read       = 1'b1;
        bus.s_address    = 30'h300;
        bus.s_burstcount = 5'd1;
        bus.s_writedata  = 32'h77;
        bus.s_byteenable = 4'hF;
        step();
        bus.s_write = 1'b0;
        bus.s_read  = 1'b0;
        check("wr_wins_wait", 32'(bus.s_waitrequest), 32'd0);
        check("wr_wins_state", 32'(dut.state), 32'(IDLE));
        pend.push_back(32'h77);
        issue_read(30'h300, 5'd1);
        wait_window(1);

        // reset during beat 5 of a line read
        for (int i = 0; i < 5; i++) pend.push_back(32'(i));
        issue_read(30'h40, 5'd16);
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("mid_rst_wait", 32'(bus.s_waitrequest), 32'd1);
        step();
        check("mid_rst_rdv", 32'(bus.s_readdatavalid), 32'd0);
        check("mid_rst_wait2", 32'(bus.s_waitrequest), 32'd1);
        step();
        rst = 1'b0;
        #1;
        check("mid_rel_wait", 32'(bus.s_waitrequest), 32'd0);
        pend.push_back(32'hDEADBEEF);
        issue_read(30'h10, 5'd1);
        wait_window(1);

        repeat (5) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
